y_multicycle_ctrl: RTL
======================

Name: y_multicycle_ctrl

Overview:
Multi-cycle control unit for the y-series MIPS datapath (yIF/yID/yEX/yDM/yWB/yPC). It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives every datapath strobe. It supports variable-latency memory via a mem_ready handshake, a timeout watchdog, interrupt redirect to an entry point, a trap on illegal opcodes, and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory access may wait for mem_ready before TRAP (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ins  in  32  current instruction from the IR (valid from the cycle after ir_write)
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
int_req  in  1  interrupt request, level
pc_write  out  1  PC load strobe
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=entryPoint
ir_write  out  1  IR load strobe
reg_dst  out  1  1=rd, 0=rt
reg_write  out  1  register-file write strobe
alu_src  out  1  1=immediate operand
mem_read  out  1  data/instruction memory read request
mem_write  out  1  memory write request
mem2reg  out  1  writeback selects memory data
alu_op  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
trap  out  1  sticky error flag
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset: state=ENTRY, wait_cnt=0, trap=0, retired=0; all strobes 0 while rst_n low; alu_op=010, pc_src=0.
- Outputs are combinational from state and ins; pc_write and ir_write also depend on zero and mem_ready (Mealy). State, wait_cnt, trap and retired are registered.
- ENTRY: pc_write=1, pc_src=3; next state FETCH. trap is cleared on entering FETCH from ENTRY.
- FETCH: mem_read=1. When mem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE. Otherwise wait_cnt++; when wait_cnt reaches MEM_TIMEOUT, go to TRAP.
- DECODE by ins[31:26]:
  - 0x00 (R-type) and 0x08 (addi): go to EXEC.
  - 0x23 (lw), 0x2b (sw), 0x04 (beq): go to EXEC.
  - 0x02 (j): pc_write=1, pc_src=2, instruction complete.
  - Any other opcode: go to TRAP.
- EXEC:
  - R-type: alu_src=0; alu_op from funct (0x24 and, 0x25 or, 0x20 add, 0x22 sub, 0x2a slt); any other funct goes to TRAP. Next state WB.
  - addi, lw, sw: alu_src=1, alu_op=010. addi goes to WB; lw and sw go to MEM.
  - beq: alu_src=0, alu_op=110, pc_write=zero, pc_src=1; instruction complete.
- MEM: lw asserts mem_read and sw asserts mem_write, held until mem_ready. wait_cnt timeout applies as in FETCH. On mem_ready, lw goes to WB and sw completes.
- WB: reg_write=1. reg_dst=1 for R-type, else 0. mem2reg=1 for lw only. Instruction complete.
- Instruction complete means retired++ (wraps at 2^CNT_W) and the next state is FETCH.
- wait_cnt clears on every state change.
- Interrupt: int_req is sampled only at instruction completion. If it is high, the next state is ENTRY instead of FETCH; retired still increments.
- TRAP: all strobes 0, trap=1. Leaves only to ENTRY when int_req=1, or via reset.
- Latencies with mem_ready=1 every cycle: j 2, beq 3, R/addi/sw 4, lw 5 cycles.
- int_req held high continuously: one instruction executes between successive ENTRY visits.
- Reset asserted mid-instruction: immediate return to ENTRY; no partial strobe survives.

Optional Feature:
CTRL_BNE_EN
- Defined: opcode 0x05 (bne) decodes like beq, with pc_write=~zero in EXEC.
- Undefined: 0x05 is illegal and goes to TRAP.

Decomposition:
- Package y_ctrl_pkg: state enum (ENTRY, FETCH, DECODE, EXEC, MEM, WB, TRAP), pc_src codes, opcode and funct constants, alu_op codes.
- Sub-module y_alu_decode: combinational funct-to-alu_op mapping plus an illegal-funct flag.

Test Plan:
- Reset release, mem_ready=1, ins=add (0x00851020) -> ENTRY (pc_write, pc_src=3), then FETCH/DECODE/EXEC(alu_op=010)/WB(reg_write=1, reg_dst=1); retired=1 after 5 cycles.
- lw (0x8C820004) with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem2reg=1; total 8 cycles.
- beq with zero=1 -> pc_write=1, pc_src=1 in EXEC; with zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- mem_ready stuck low in FETCH -> trap=1 after exactly MEM_TIMEOUT (15) wait cycles; int_req=1 -> ENTRY, trap clears on entering FETCH.
- Opcode 0x05: with CTRL_BNE_EN defined and zero=0 -> branch taken; without the macro -> TRAP.
- int_req raised during EXEC of sw -> sw completes (mem_write until mem_ready), retired increments, next state ENTRY; counter wrap checked with CNT_W=2 after 4 instructions -> retired=0.

Source files
------------

// File: rtl/y_ctrl_pkg.sv
// Shared encodings for the y-series multi-cycle control unit: states, PC source
// selects, opcode/funct values and ALU operation codes.
package y_ctrl_pkg;

    localparam logic [2:0] ST_ENTRY  = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_ENTRY  = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/y_alu_decode.sv
// R-type funct to ALU operation mapping; unknown functs default to add and
// raise o_illegal so the controller can trap.
module y_alu_decode
    import y_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_illegal
);

    always_comb begin
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
        case (i_funct)
            FN_AND:  o_alu_op = ALU_AND;
            FN_OR:   o_alu_op = ALU_OR;
            FN_ADD:  o_alu_op = ALU_ADD;
            FN_SUB:  o_alu_op = ALU_SUB;
            FN_SLT:  o_alu_op = ALU_SLT;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/y_multicycle_ctrl.sv
// Multi-cycle FSM controller for the y-series MIPS datapath with memory wait
// watchdog, interrupt redirect, illegal-op trap and retire counter. Macro CTRL_BNE_EN enables bne.
module y_multicycle_ctrl
    import y_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             int_req,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem2reg,
    output logic [2:0]       alu_op,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [7:0]       r_wait;
    logic             r_trap;
    logic [CNT_W-1:0] r_retired;

    logic [2:0] w_next;
    logic       w_done, w_waiting;
    logic       w_pc_write, w_ir_write, w_reg_dst, w_reg_write, w_alu_src;
    logic       w_mem_read, w_mem_write, w_mem2reg;
    logic [1:0] w_pc_src;
    logic [2:0] w_alu_op, w_r_alu_op;
    logic       w_funct_bad;
    logic       w_unused;

    logic [5:0] w_op;
    logic       w_is_r, w_is_addi, w_is_lw, w_is_j, w_is_beq, w_is_bne, w_is_br;
    logic       w_br_take;

    assign w_op      = ins[31:26];
    assign w_unused  = ^ins[25:6];
    assign w_is_r    = (w_op == OP_RTYPE);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_j    = (w_op == OP_J);
    assign w_is_beq  = (w_op == OP_BEQ);
`ifdef CTRL_BNE_EN
    assign w_is_bne  = (w_op == OP_BNE);
`else
    assign w_is_bne  = 1'b0;
`endif
    assign w_is_br   = w_is_beq | w_is_bne;
    assign w_br_take = w_is_bne ? ~zero : zero;

    y_alu_decode u_alu_decode (
        .i_funct   (ins[5:0]),
        .o_alu_op  (w_r_alu_op),
        .o_illegal (w_funct_bad)
    );

    always_comb begin
        w_next      = r_state;
        w_done      = 1'b0;
        w_waiting   = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = PC_SEQ;
        w_ir_write  = 1'b0;
        w_reg_dst   = 1'b0;
        w_reg_write = 1'b0;
        w_alu_src   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem2reg   = 1'b0;
        w_alu_op    = ALU_ADD;
        case (r_state)
            ST_ENTRY: begin
                w_pc_write = 1'b1;
                w_pc_src   = PC_ENTRY;
                w_next     = ST_FETCH;
            end
            ST_FETCH: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = ST_DECODE;
                end else begin
                    w_waiting = 1'b1;
                    if (r_wait >= WAIT_LAST) w_next = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (w_is_j) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = PC_JUMP;
                    w_done     = 1'b1;
                end else if (w_is_r || w_is_addi || is_mem_op(w_op) || w_is_br) begin
                    w_next = ST_EXEC;
                end else begin
                    w_next = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (w_is_r) begin
                    w_alu_op = w_r_alu_op;
                    w_next   = w_funct_bad ? ST_TRAP : ST_WB;
                end else if (w_is_br) begin
                    w_alu_op   = ALU_SUB;
                    w_pc_write = w_br_take;
                    w_pc_src   = PC_BRANCH;
                    w_done     = 1'b1;
                end else begin
                    w_alu_src = 1'b1;
                    w_next    = w_is_addi ? ST_WB : ST_MEM;
                end
            end
            ST_MEM: begin
                w_mem_read  = w_is_lw;
                w_mem_write = ~w_is_lw;
                if (mem_ready) begin
                    if (w_is_lw) w_next = ST_WB;
                    else         w_done = 1'b1;
                end else begin
                    w_waiting = 1'b1;
                    if (r_wait >= WAIT_LAST) w_next = ST_TRAP;
                end
            end
            ST_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = w_is_r;
                w_mem2reg   = w_is_lw;
                w_done      = 1'b1;
            end
            ST_TRAP: begin
                if (int_req) w_next = ST_ENTRY;
            end
            default: w_next = ST_ENTRY;
        endcase
        // Interrupts are only taken on an instruction boundary.
        if (w_done) w_next = int_req ? ST_ENTRY : ST_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ENTRY;
            r_wait    <= 8'd0;
            r_trap    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_wait <= 8'd0;
            else if (w_waiting)    r_wait <= r_wait + 8'd1;
            if (w_next == ST_TRAP)       r_trap <= 1'b1;
            else if (r_state == ST_ENTRY) r_trap <= 1'b0;
            if (w_done) r_retired <= r_retired + 1'b1;
        end
    end

    // Strobes are forced low while reset is held, independent of state decode.
    assign pc_write  = w_pc_write  & rst_n;
    assign ir_write  = w_ir_write  & rst_n;
    assign reg_dst   = w_reg_dst   & rst_n;
    assign reg_write = w_reg_write & rst_n;
    assign alu_src   = w_alu_src   & rst_n;
    assign mem_read  = w_mem_read  & rst_n;
    assign mem_write = w_mem_write & rst_n;
    assign mem2reg   = w_mem2reg   & rst_n;
    assign pc_src    = rst_n ? w_pc_src : PC_SEQ;
    assign alu_op    = rst_n ? w_alu_op : ALU_ADD;
    assign trap      = r_trap;
    assign retired   = r_retired;

endmodule
